// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect/halt
// controls and the decode-side valid/ready handshake.
interface fetch_prefetch_queue_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              dec_valid;
   logic              dec_ready;
   logic [DATA_W-1:0] dec_instr;
   logic [ADDR_W-1:0] dec_pc;
   logic [ADDR_W-1:0] dec_pc_next;
   logic [CNT_W-1:0]  count;
   logic              proto_err;

   // Fetch unit side
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect, redirect_pc, halt,
      output dec_valid, dec_instr, dec_pc, dec_pc_next, count, proto_err,
      input  dec_ready
   );

   // Memory / pipeline side
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect, redirect_pc, halt,
      input  dec_valid, dec_instr, dec_pc, dec_pc_next, count, proto_err,
      output dec_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues in-order fetches against a variable
// latency memory, tags each request with its PC and buffers returned
// instructions for decode. Redirect flushes and drops in-flight responses.
module fetch_prefetch_queue #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       PC_INC   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                    clk,
   input logic                    rst_n,
   fetch_prefetch_queue_if.master bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]  tag_wr_q, tag_wr_d;
   logic [IDX_W-1:0]  tag_rd_q, tag_rd_d;
   logic              proto_err_q, proto_err_d;
   logic [DATA_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0] pc_q    [DEPTH];
   logic [ADDR_W-1:0] tag_q   [DEPTH];

   logic [CNT_W-1:0]  count_c;
   logic              credit_ok_c;
   logic              req_valid_c;
   logic              issue_c;
   logic              rsp_ok_c;
   logic              rsp_bad_c;
   logic              dec_valid_c;
   logic              push_c;
   logic              pop_c;

   // Occupancy, credit check and handshake qualifiers
   always_comb begin
      count_c     = wr_ptr_q - rd_ptr_q;
      credit_ok_c = (SUM_W'(count_c) + SUM_W'(outst_q)) < SUM_W'(DEPTH);
      req_valid_c = rst_n & ~bus.halt & ~bus.redirect & credit_ok_c;
      issue_c     = req_valid_c & bus.imem_req_ready;
      rsp_ok_c    = bus.imem_rsp_valid & (outst_q != '0);
      rsp_bad_c   = bus.imem_rsp_valid & (outst_q == '0);
      dec_valid_c = (count_c != '0);
      push_c      = rsp_ok_c & (drop_q == '0) & ~bus.redirect;
      pop_c       = dec_valid_c & bus.dec_ready & ~bus.redirect;
   end

   // Next-state for PC, credit counters and queue/tag pointers
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      outst_d     = outst_q + CNT_W'(issue_c) - CNT_W'(rsp_ok_c);
      drop_d      = drop_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      tag_wr_d    = tag_wr_q + IDX_W'(issue_c);
      tag_rd_d    = tag_rd_q + IDX_W'(rsp_ok_c);
      proto_err_d = proto_err_q | rsp_bad_c;
      if (bus.redirect) begin
         // every request still in flight belongs to the abandoned path
         fetch_pc_d = bus.redirect_pc;
         drop_d     = drop_q + outst_q - CNT_W'(rsp_ok_c);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (issue_c) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
         if (rsp_ok_c && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
         if (push_c) wr_ptr_d = wr_ptr_q + CNT_W'(1);
         if (pop_c) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q  <= RESET_PC;
         outst_q     <= '0;
         drop_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_wr_q    <= '0;
         tag_rd_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tag_wr_q    <= tag_wr_d;
         tag_rd_q    <= tag_rd_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Queue storage and in-order PC tag FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         if (push_c) begin
            instr_q[wr_ptr_q[IDX_W-1:0]] <= bus.imem_rsp_data;
            pc_q[wr_ptr_q[IDX_W-1:0]]    <= tag_q[tag_rd_q];
         end
         if (issue_c) tag_q[tag_wr_q] <= fetch_pc_q;
      end
   end

   assign bus.imem_req_valid = req_valid_c;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.dec_valid      = dec_valid_c;
   assign bus.dec_instr      = instr_q[rd_ptr_q[IDX_W-1:0]];
   assign bus.dec_pc         = pc_q[rd_ptr_q[IDX_W-1:0]];
   assign bus.dec_pc_next    = pc_q[rd_ptr_q[IDX_W-1:0]] + ADDR_W'(PC_INC);
   assign bus.count          = count_c;
   assign bus.proto_err      = proto_err_q;
endmodule
